// File: rtl/nn_pkg.sv
// Shared FSM state type, default engine parameters and activation reduction.
// Build option NN_SAT_EN: saturate activations to DW bits instead of wrapping.
package nn_pkg;

  typedef enum logic [2:0] {
    IDLE,
    MAC,
    ACT,
    ARGMAX,
    DONE
  } nn_state_e;

  localparam int unsigned NN_DW       = 8;
  localparam int unsigned NN_N_IN     = 62;
  localparam int unsigned NN_N_PAR    = 10;
  localparam int unsigned NN_N_LAYERS = 3;
  localparam int unsigned NN_FRAC     = 4;

`ifdef NN_SAT_EN
  localparam bit NN_SAT = 1'b1;
`else
  localparam bit NN_SAT = 1'b0;
`endif

  // Clamp to the signed dw-bit range when saturating; callers keep the low dw bits,
  // so the non-saturating build wraps in two's complement.
  function automatic logic signed [63:0] nn_reduce(input logic signed [63:0] v,
                                                   input int unsigned dw);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (dw - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (dw - 1));
    if (NN_SAT && (v > hi)) return hi;
    if (NN_SAT && (v < lo)) return lo;
    return v;
  endfunction

endpackage

// File: rtl/nn_mac_lane.sv
// One neuron lane: bias-initialised accumulator, fixed-point rescale, optional ReLU
// and reduction to DW bits (saturation selected by NN_SAT_EN in nn_pkg).
module nn_mac_lane import nn_pkg::*; #(
  parameter int unsigned DW   = NN_DW,
  parameter int unsigned AW   = 2 * NN_DW + $clog2(NN_N_IN + 1) + 1,
  parameter int unsigned FRAC = NN_FRAC
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 init_i,
  input  logic                 acc_en_i,
  input  logic                 relu_en_i,
  input  logic signed [DW-1:0] x_i,
  input  logic signed [DW-1:0] w_i,
  output logic signed [DW-1:0] act_o
);

  logic signed [AW-1:0]   acc_q;
  logic signed [AW-1:0]   acc_d;
  logic signed [AW-1:0]   shifted;
  logic signed [2*DW-1:0] prod;

  always_comb begin
    prod  = x_i * w_i;
    acc_d = acc_q;
    if (init_i) begin
      acc_d = AW'(w_i) <<< FRAC;
    end else if (acc_en_i) begin
      acc_d = acc_q + AW'(prod);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  always_comb begin
    shifted = acc_q >>> FRAC;
    if (relu_en_i && shifted[AW-1]) begin
      shifted = '0;
    end
    act_o = DW'(nn_reduce(64'(shifted), DW));
  end

endmodule

// File: rtl/mlp_layer_engine.sv
// Layer-serial MLP inference engine: N_PAR parallel lanes stream weights row by row,
// then the output layer's scores are reduced to a class index (build option NN_SAT_EN).
module mlp_layer_engine import nn_pkg::*; #(
  parameter int unsigned DW       = NN_DW,
  parameter int unsigned N_IN     = NN_N_IN,
  parameter int unsigned N_PAR    = NN_N_PAR,
  parameter int unsigned N_LAYERS = NN_N_LAYERS,
  parameter int unsigned FRAC     = NN_FRAC
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   in_valid,
  output logic                                   in_ready,
  input  logic [N_IN*DW-1:0]                     in_data,
  output logic [$clog2(N_LAYERS*(N_IN+1))-1:0]   w_addr,
  input  logic [N_PAR*DW-1:0]                    w_data,
  output logic                                   out_valid,
  input  logic                                   out_ready,
  output logic [N_PAR*DW-1:0]                    scores,
  output logic [$clog2(N_PAR)-1:0]               class_out
);

  localparam int unsigned ADDR_W = $clog2(N_LAYERS * (N_IN + 1));
  localparam int unsigned AW     = 2 * DW + $clog2(N_IN + 1) + 1;
  localparam int unsigned CNT_W  = $clog2(N_IN + 2);
  localparam int unsigned LYR_W  = (N_LAYERS > 1) ? $clog2(N_LAYERS) : 1;
  localparam int unsigned CLS_W  = $clog2(N_PAR);
  localparam int unsigned ROWS   = N_IN + 1;

  nn_state_e             state_q;
  logic [CNT_W-1:0]      cnt_q;
  logic [LYR_W-1:0]      layer_q;
  logic [ADDR_W-1:0]     w_addr_q;
  logic                  in_ready_q;
  logic                  out_valid_q;
  logic [N_PAR*DW-1:0]   scores_q;
  logic [CLS_W-1:0]      class_q;
  logic [CLS_W-1:0]      class_d;
  logic [DW-1:0]         x_q [N_IN];

  logic [CNT_W-1:0]      fanin;
  logic [CNT_W-1:0]      x_idx;
  logic signed [DW-1:0]  x_sel;
  logic signed [DW-1:0]  best_val;
  logic [ADDR_W-1:0]     next_base;
  logic                  lane_init;
  logic                  lane_acc;
  logic                  last_layer;
  logic [N_PAR*DW-1:0]   act;

  always_comb begin
    fanin      = (layer_q == '0) ? CNT_W'(N_IN) : CNT_W'(N_PAR);
    last_layer = (layer_q == LYR_W'(N_LAYERS - 1));
    next_base  = ADDR_W'((layer_q + 1'b1) * ROWS);
    // Read data trails the address by one cycle: count 1 carries the bias row,
    // count k>=2 carries the weights for input k-2.
    lane_init  = (state_q == MAC) && (cnt_q == CNT_W'(1));
    lane_acc   = (state_q == MAC) && (cnt_q >= CNT_W'(2));
    x_idx      = cnt_q - CNT_W'(2);
    x_sel      = '0;
    for (int unsigned i = 0; i < N_IN; i++) begin
      if (x_idx == CNT_W'(i)) begin
        x_sel = x_q[i];
      end
    end
  end

  for (genvar j = 0; j < N_PAR; j++) begin : g_lane
    nn_mac_lane #(
      .DW  (DW),
      .AW  (AW),
      .FRAC(FRAC)
    ) u_lane (
      .clk      (clk),
      .rst      (rst),
      .init_i   (lane_init),
      .acc_en_i (lane_acc),
      .relu_en_i(!last_layer),
      .x_i      (x_sel),
      .w_i      (w_data[j*DW +: DW]),
      .act_o    (act[j*DW +: DW])
    );
  end

  // Strict greater-than keeps the lowest index on ties.
  always_comb begin
    best_val = scores_q[DW-1:0];
    class_d  = '0;
    for (int unsigned j = 1; j < N_PAR; j++) begin
      if ($signed(scores_q[j*DW +: DW]) > best_val) begin
        best_val = scores_q[j*DW +: DW];
        class_d  = CLS_W'(j);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      layer_q     <= '0;
      w_addr_q    <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      scores_q    <= '0;
      class_q     <= '0;
      for (int unsigned i = 0; i < N_IN; i++) begin
        x_q[i] <= '0;
      end
    end else begin
      unique case (state_q)
        IDLE: begin
          if (in_valid) begin
            for (int unsigned i = 0; i < N_IN; i++) begin
              x_q[i] <= in_data[i*DW +: DW];
            end
            layer_q    <= '0;
            cnt_q      <= '0;
            w_addr_q   <= '0;
            in_ready_q <= 1'b0;
            state_q    <= MAC;
          end
        end
        MAC: begin
          if (cnt_q < fanin) begin
            w_addr_q <= w_addr_q + 1'b1;
          end
          if (cnt_q == fanin + 1'b1) begin
            cnt_q   <= '0;
            state_q <= ACT;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        ACT: begin
          for (int unsigned j = 0; j < N_PAR; j++) begin
            x_q[j] <= act[j*DW +: DW];
          end
          if (last_layer) begin
            scores_q <= act;
            state_q  <= ARGMAX;
          end else begin
            layer_q  <= layer_q + 1'b1;
            w_addr_q <= next_base;
            state_q  <= MAC;
          end
        end
        ARGMAX: begin
          class_q     <= class_d;
          out_valid_q <= 1'b1;
          state_q     <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign w_addr    = w_addr_q;
  assign scores    = scores_q;
  assign class_out = class_q;

endmodule

// File: tb/tb_mlp_layer_engine.sv
// Directed bench for mlp_layer_engine at default parameters with a registered weight memory.
module tb_mlp_layer_engine;

  localparam int DW       = 8;
  localparam int N_IN     = 62;
  localparam int N_PAR    = 10;
  localparam int N_LAYERS = 3;
  localparam int FRAC     = 4;
  localparam int ROWS     = N_IN + 1;
  localparam int ADDR_W   = 8;
  localparam int CLS_W    = 4;
  localparam int LATENCY  = 92;
  localparam int LAST_ADDR = 2 * ROWS + N_PAR;
`ifdef NN_SAT_EN
  localparam int BIG_ACT = 127;
`else
  localparam int BIG_ACT = 35;
`endif

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 in_valid;
  logic                 in_ready;
  logic [N_IN*DW-1:0]   in_data;
  logic [ADDR_W-1:0]    w_addr;
  logic [N_PAR*DW-1:0]  w_data;
  logic                 out_valid;
  logic                 out_ready;
  logic [N_PAR*DW-1:0]  scores;
  logic [CLS_W-1:0]     class_out;
  logic [N_PAR*DW-1:0]  mem [N_LAYERS*ROWS];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) w_data <= mem[w_addr];

  mlp_layer_engine #(
    .DW(DW), .N_IN(N_IN), .N_PAR(N_PAR), .N_LAYERS(N_LAYERS), .FRAC(FRAC)
  ) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .w_addr(w_addr), .w_data(w_data), .out_valid(out_valid), .out_ready(out_ready),
    .scores(scores), .class_out(class_out)
  );

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic clear_mem();
    for (int r = 0; r < N_LAYERS * ROWS; r++) mem[r] = '0;
  endtask

  task automatic set_w(input int layer, input int row, input int lane, input int val);
    mem[layer*ROWS + row][lane*DW +: DW] = DW'(val);
  endtask

  task automatic rand_vec(output logic [N_IN*DW-1:0] v);
    for (int i = 0; i < N_IN; i++) v[i*DW +: DW] = DW'($urandom_range(0, 255));
  endtask

  task automatic run_vec(input logic [N_IN*DW-1:0] vec, output int lat);
    @(negedge clk);
    in_data  = vec;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    lat = 0;
    while (out_valid !== 1'b1 && lat < 400) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic release_out();
    @(negedge clk);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic load_ramp();
    clear_mem();
    for (int l = 0; l < N_LAYERS; l++)
      for (int j = 0; j < N_PAR; j++) set_w(l, 0, j, j);
  endtask

  task automatic check_ramp(input string tag);
    for (int j = 0; j < N_PAR; j++) begin
      checks++;
      if (scores[j*DW +: DW] !== DW'(j)) begin
        errors++;
        $display("FAIL %s score[%0d]: got %0d want %0d", tag, j, $signed(scores[j*DW +: DW]), j);
      end
    end
    checks++;
    if (class_out !== CLS_W'(9)) begin
      errors++;
      $display("FAIL %s class: got %0d want 9", tag, class_out);
    end
  endtask

  task automatic test_reset();
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset in_ready: got %b want 1", in_ready); end
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset out_valid: got %b want 0", out_valid); end
    checks++;
    if (scores !== '0) begin errors++; $display("FAIL reset scores: got %h want 0", scores); end
    checks++;
    if (class_out !== '0) begin errors++; $display("FAIL reset class: got %0d want 0", class_out); end
    checks++;
    if (w_addr !== '0) begin errors++; $display("FAIL reset w_addr: got %0d want 0", w_addr); end
  endtask

  task automatic test_bias_ramp();
    logic [N_IN*DW-1:0] v;
    int lat;
    load_ramp();
    rand_vec(v);
    run_vec(v, lat);
    checks++;
    if (lat != LATENCY) begin errors++; $display("FAIL ramp latency: got %0d want %0d", lat, LATENCY); end
    check_ramp("ramp");
    checks++;
    if (w_addr !== ADDR_W'(LAST_ADDR)) begin
      errors++; $display("FAIL ramp w_addr hold: got %0d want %0d", w_addr, LAST_ADDR);
    end
    release_out();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL ramp release: got valid=%b ready=%b want 0/1", out_valid, in_ready);
    end
  endtask

  task automatic test_tie();
    logic [N_IN*DW-1:0] v;
    int lat;
    clear_mem();
    for (int j = 0; j < N_PAR; j++) begin
      set_w(0, 0, j, int'($urandom_range(0, 255)) - 128);
      set_w(1, 0, j, int'($urandom_range(0, 255)) - 128);
      set_w(2, 0, j, 5);
    end
    rand_vec(v);
    run_vec(v, lat);
    for (int j = 0; j < N_PAR; j++) begin
      checks++;
      if (scores[j*DW +: DW] !== DW'(5)) begin
        errors++; $display("FAIL tie score[%0d]: got %0d want 5", j, $signed(scores[j*DW +: DW]));
      end
    end
    checks++;
    if (class_out !== '0) begin errors++; $display("FAIL tie class: got %0d want 0", class_out); end
    release_out();
  endtask

  task automatic test_relu();
    logic [N_IN*DW-1:0] v;
    int lat;
    clear_mem();
    for (int j = 0; j < N_PAR; j++) begin
      set_w(1, 0, j, -3);
      set_w(2, 0, j, j);
      for (int r = 1; r <= N_PAR; r++) set_w(2, r, j, 16);
    end
    rand_vec(v);
    run_vec(v, lat);
    check_ramp("relu");
    release_out();
  endtask

  task automatic test_sat();
    logic [N_IN*DW-1:0] v;
    int lat;
    clear_mem();
    for (int j = 0; j < N_PAR; j++) begin
      for (int r = 1; r <= N_IN; r++) set_w(0, r, j, 127);
      set_w(1, j + 1, j, 16);
      set_w(2, j + 1, j, 16);
    end
    for (int i = 0; i < N_IN; i++) v[i*DW +: DW] = 8'd127;
    run_vec(v, lat);
    for (int j = 0; j < N_PAR; j++) begin
      checks++;
      if (scores[j*DW +: DW] !== DW'(BIG_ACT)) begin
        errors++; $display("FAIL sat score[%0d]: got %0d want %0d", j, $signed(scores[j*DW +: DW]), BIG_ACT);
      end
    end
    checks++;
    if (class_out !== '0) begin errors++; $display("FAIL sat class: got %0d want 0", class_out); end
    release_out();
  endtask

  task automatic load_mixed();
    clear_mem();
    for (int j = 0; j < N_PAR; j++) begin
      set_w(0, 0, j, 1);
      set_w(0, 1, j, 16);
      set_w(0, 2, j, 8 * j);
      set_w(0, N_IN, j, 8);
      set_w(1, j + 1, j, 16);
    end
    for (int j = 0; j < N_PAR; j++)
      if (j < 5 || j > 7) set_w(2, j + 1, j, 16);
    set_w(2, 1, 5, -3);
    set_w(2, 0, 6, 2);
    set_w(2, 2, 6, 24);
    set_w(2, 0, 7, -10);
    for (int r = 1; r <= N_PAR; r++) set_w(2, r, 7, 16);
  endtask

  task automatic mixed_vec(output logic [N_IN*DW-1:0] v);
    rand_vec(v);
    v[0*DW +: DW]        = 8'd3;
    v[1*DW +: DW]        = 8'hFC;
    v[(N_IN-1)*DW +: DW] = 8'd5;
  endtask

  task automatic test_mixed();
    logic [N_IN*DW-1:0] v;
    int lat;
    int exp_s [N_PAR] = '{6, 4, 2, 0, 0, -2, 8, 2, 0, 0};
    load_mixed();
    mixed_vec(v);
    run_vec(v, lat);
    for (int j = 0; j < N_PAR; j++) begin
      checks++;
      if (scores[j*DW +: DW] !== DW'(exp_s[j])) begin
        errors++; $display("FAIL mixed score[%0d]: got %0d want %0d", j, $signed(scores[j*DW +: DW]), exp_s[j]);
      end
    end
    checks++;
    if (class_out !== CLS_W'(6)) begin errors++; $display("FAIL mixed class: got %0d want 6", class_out); end
    release_out();
  endtask

  task automatic test_back_to_back_hold();
    logic [N_IN*DW-1:0] v;
    logic [N_PAR*DW-1:0] exp_p;
    int lat;
    int exp_s [N_PAR] = '{6, 4, 2, 0, 0, -2, 8, 2, 0, 0};
    for (int j = 0; j < N_PAR; j++) exp_p[j*DW +: DW] = DW'(exp_s[j]);
    mixed_vec(v);
    run_vec(v, lat);
    checks++;
    if (lat != LATENCY) begin errors++; $display("FAIL hold latency: got %0d want %0d", lat, LATENCY); end
    for (int c = 0; c < 10; c++) begin
      in_valid = 1'b1;
      in_data  = ~v;
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
        errors++; $display("FAIL hold handshake cyc %0d: got valid=%b ready=%b want 1/0", c, out_valid, in_ready);
      end
      checks++;
      if (scores !== exp_p) begin errors++; $display("FAIL hold scores cyc %0d: got %h want %h", c, scores, exp_p); end
      checks++;
      if (class_out !== CLS_W'(6)) begin errors++; $display("FAIL hold class cyc %0d: got %0d want 6", c, class_out); end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL hold release: got valid=%b ready=%b want 0/1", out_valid, in_ready);
    end
    @(negedge clk);
    checks++;
    if (w_addr !== ADDR_W'(LAST_ADDR) || in_ready !== 1'b1) begin
      errors++; $display("FAIL idle hold: got w_addr=%0d ready=%b want %0d/1", w_addr, in_ready, LAST_ADDR);
    end
  endtask

  task automatic test_reset_mid_run();
    logic [N_IN*DW-1:0] v;
    int lat;
    load_ramp();
    rand_vec(v);
    @(negedge clk);
    in_data  = v;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (40) @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL midreset async: got valid=%b ready=%b want 0/1", out_valid, in_ready);
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL midreset release: got valid=%b ready=%b want 0/1", out_valid, in_ready);
    end
    checks++;
    if (scores !== '0 || class_out !== '0 || w_addr !== '0) begin
      errors++; $display("FAIL midreset values: got scores=%h class=%0d w_addr=%0d want 0", scores, class_out, w_addr);
    end
    rand_vec(v);
    run_vec(v, lat);
    checks++;
    if (lat != LATENCY) begin errors++; $display("FAIL midreset latency: got %0d want %0d", lat, LATENCY); end
    check_ramp("midreset");
    release_out();
  endtask

  initial begin
    rst       = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_data   = '0;
    clear_mem();
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    test_reset();
    test_bias_ramp();
    test_tie();
    test_relu();
    test_sat();
    test_mixed();
    test_back_to_back_hold();
    test_reset_mid_run();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
